// File: rtl/sprite_rom_arbiter_pkg.sv
// sprite_rom_arbiter_pkg: shared widths and helpers for the sprite ROM arbiter
package sprite_rom_arbiter_pkg;
  localparam int NREQ_DEF  = 4;
  localparam int DEPTH_DEF = 960;
  localparam int CIDXW     = 3;
  localparam int DATAW_DEF = CIDXW;
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r |= oh[i] ? 3'(i) : 3'd0;
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant with a line-start reset of the priority pointer
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_line,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_winner_idx,
  output logic            o_grant_valid
);
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_start;
  logic [IW-1:0] w_cand;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_next;
  logic          w_found;
  always_comb begin
    w_start = i_line ? '0 : r_ptr;
    w_cand  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    // scan downwards so the candidate closest to the start is the last to win
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = IW'((int'(w_start) + k) % NREQ);
      if (i_req[w_cand]) begin
        w_found = rst_n;
        w_idx   = w_cand;
      end
    end
    w_next = !w_found ? w_start : (int'(w_idx) == NREQ - 1) ? '0 : w_idx + 1'b1;
  end
  assign o_gnt         = w_found ? NREQ'(1) << w_idx : '0;
  assign o_winner_idx  = w_idx;
  assign o_grant_valid = w_found;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= '0;
    else        r_ptr <= w_next;
endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one synchronous sprite ROM among NREQ requesters
module sprite_rom_arbiter import sprite_rom_arbiter_pkg::*; #(
  parameter int NREQ    = NREQ_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDRW   = addr_width(DEPTH),
  parameter int DATAW   = DATAW_DEF,
  parameter int ROM_LAT = 1,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_line,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*ADDRW-1:0] i_addr,
  output logic [NREQ-1:0]       o_gnt,
  output logic [ADDRW-1:0]      o_rom_addr,
  input  logic [DATAW-1:0]      i_rom_data,
  output logic [NREQ-1:0]       o_rd_valid,
  output logic [DATAW-1:0]      o_rd_data,
  output logic                  o_busy
);
  logic [NREQ-1:0]  w_gnt;
  logic [IW-1:0]    w_idx;
  logic             w_gv;
  logic             w_busy;
  logic [ADDRW-1:0] r_rom_addr;
  logic [NREQ-1:0]  r_rd_valid;
  logic [DATAW-1:0] r_rd_data;
  // stage 0 lines up with rom_addr, stage ROM_LAT with valid rom_data
  logic [NREQ-1:0]  r_tag [ROM_LAT+1];
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_line       (i_line),
    .i_req        (i_req),
    .o_gnt        (w_gnt),
    .o_winner_idx (w_idx),
    .o_grant_valid(w_gv)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr <= '0;
      r_rd_valid <= '0;
      r_rd_data  <= '0;
      for (int k = 0; k <= ROM_LAT; k++) r_tag[k] <= '0;
    end else begin
      if (w_gv) r_rom_addr <= i_addr[int'(w_idx)*ADDRW +: ADDRW];
      r_tag[0] <= w_gnt;
      for (int k = 1; k <= ROM_LAT; k++) r_tag[k] <= r_tag[k-1];
      r_rd_valid <= r_tag[ROM_LAT];
      if (|r_tag[ROM_LAT]) r_rd_data <= i_rom_data;
    end
  end
  always_comb begin
    w_busy = |r_rd_valid;
    for (int k = 0; k <= ROM_LAT; k++) w_busy = w_busy | (|r_tag[k]);
  end
  assign o_gnt      = w_gnt;
  assign o_rom_addr = r_rom_addr;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_busy     = w_busy;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed vectors checked against a cycle model of the arbiter
module tb_sprite_rom_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line = 1'b0;
  logic [3:0]  req = '0;
  logic [9:0]  addr_v [4];
  logic [9:0]  addr_n [4];
  logic [39:0] addr_flat;
  logic [3:0]  gnt;
  logic [9:0]  rom_addr;
  logic [2:0]  rom_data = '0;
  logic [3:0]  rd_valid;
  logic [2:0]  rd_data;
  logic        busy;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  assign addr_flat = {addr_v[3], addr_v[2], addr_v[1], addr_v[0]};

  sprite_rom_arbiter dut (
    .clk(clk), .rst_n(rst_n), .i_line(line), .i_req(req), .i_addr(addr_flat),
    .o_gnt(gnt), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_busy(busy)
  );

  function automatic logic [2:0] rom_fn(input logic [9:0] a);
    return a[2:0] ^ 3'b110;
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, want);
    end
  endtask

  // model: grant history for the last three cycles, pointer, last address and data
  int         m_ptr = 0;
  int         m_start, m_win;
  bit         hv [3];
  int         hi [3];
  logic [2:0] hd [3];
  logic [9:0] m_addr = '0;
  logic [2:0] m_data = '0;
  logic [3:0] eg, ev;
  initial begin
    for (int h = 0; h < 3; h++) begin hv[h] = 0; hi[h] = 0; hd[h] = '0; end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ptr = 0; m_addr = '0; m_data = '0;
        for (int h = 0; h < 3; h++) hv[h] = 0;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
      end else begin
        m_start = line ? 0 : m_ptr;
        m_win = -1;
        for (int k = 0; k < 4; k++)
          if (m_win < 0 && req[(m_start + k) % 4]) m_win = (m_start + k) % 4;
        eg = (m_win >= 0) ? 4'(1 << m_win) : 4'd0;
        ev = hv[2] ? 4'(1 << hi[2]) : 4'd0;
        if (hv[2]) m_data = hd[2];
        chk("gnt", 32'(gnt), 32'(eg));
        chk("rd_valid", 32'(rd_valid), 32'(ev));
        chk("rd_data", 32'(rd_data), 32'(m_data));
        chk("rom_addr", 32'(rom_addr), 32'(m_addr));
        chk("busy", 32'(busy), 32'(hv[0] | hv[1] | hv[2]));
        for (int h = 2; h > 0; h--) begin hv[h] = hv[h-1]; hi[h] = hi[h-1]; hd[h] = hd[h-1]; end
        hv[0] = (m_win >= 0);
        hi[0] = (m_win >= 0) ? m_win : 0;
        hd[0] = (m_win >= 0) ? rom_fn(addr_v[m_win]) : 3'd0;
        if (m_win >= 0) m_addr = addr_v[m_win];
        m_ptr = (m_win >= 0) ? (m_win + 1) % 4 : m_start;
      end
    end
  end

  task automatic step(input logic rn, input logic ln, input logic [3:0] rq);
    @(posedge clk);
    #1;
    rst_n = rn; line = ln; req = rq;
    for (int i = 0; i < 4; i++) addr_v[i] = addr_n[i];
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] seq [4];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin addr_v[i] = '0; addr_n[i] = '0; end
    step(0, 0, 4'b0000);
    step(0, 0, 4'b0000);
    // single request: full latency path
    addr_n[0] = 10'd5;
    step(1, 0, 4'b0001); chk("t1_gnt", 32'(gnt), 32'b0001);
    step(1, 0, 4'b0000); chk("t1_rom_addr", 32'(rom_addr), 5); chk("t1_busy1", 32'(busy), 1);
    step(1, 0, 4'b0000); chk("t1_busy2", 32'(busy), 1);
    step(1, 0, 4'b0000); chk("t1_rd_valid", 32'(rd_valid), 32'b0001);
    chk("t1_rd_data", 32'(rd_data), 3); chk("t1_busy3", 32'(busy), 1);
    step(1, 0, 4'b0000); chk("t1_idle", 32'(busy), 0);
    // all requesting: rotation and return order
    for (int i = 0; i < 4; i++) addr_n[i] = 10'(i);
    for (int k = 0; k < 8; k++) begin
      step(1, k == 0, 4'b1111);
      chk("t2_gnt", 32'(gnt), 32'(seq[k % 4]));
      if (k >= 3) begin
        chk("t2_rd_valid", 32'(rd_valid), 32'(seq[(k - 3) % 4]));
        chk("t2_rd_data", 32'(rd_data), 32'(3'((k - 3) % 4) ^ 3'b110));
      end
    end
    for (int k = 0; k < 4; k++) step(1, 0, 4'b0000);
    // pointer 2, requesters 1 and 3
    step(1, 0, 4'b0010);
    step(1, 0, 4'b1010); chk("t3_gnt_a", 32'(gnt), 32'b1000);
    step(1, 0, 4'b0010); chk("t3_gnt_b", 32'(gnt), 32'b0010);
    // line start overrides pointer 2
    step(1, 1, 4'b1111); chk("t4_gnt_line", 32'(gnt), 32'b0001);
    step(1, 0, 4'b1111); chk("t4_gnt_next", 32'(gnt), 32'b0010);
    step(1, 0, 4'b1111); chk("t4_gnt_ptr2", 32'(gnt), 32'b0100);
    // idle with pointer 3
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 4'b0000);
      chk("t6_gnt", 32'(gnt), 0);
      chk("t6_rom_addr", 32'(rom_addr), 2);
    end
    step(1, 0, 4'b1111); chk("t6_gnt_ptr3", 32'(gnt), 32'b1000);
    for (int k = 0; k < 4; k++) step(1, 0, 4'b0000);
    // reset with reads in flight
    addr_n[0] = 10'd10; addr_n[1] = 10'd11;
    step(1, 0, 4'b0001); chk("t5_gnt0", 32'(gnt), 32'b0001);
    step(1, 0, 4'b0010); chk("t5_gnt1", 32'(gnt), 32'b0010);
    step(0, 0, 4'b0000); chk("t5_rd_valid_rst", 32'(rd_valid), 0); chk("t5_busy_rst", 32'(busy), 0);
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 4'b0000);
      chk("t5_rd_valid_after", 32'(rd_valid), 0);
      chk("t5_busy_after", 32'(busy), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
